ch_nibble_packer: RTL
=====================

Name: ch_nibble_packer

Overview:
Downstream consumer of the 4-bit ch_queue dequeue port. It gathers RATIO consecutive narrow beats into one wide word and presents that word on a valid/ready output.
- Both sides use the same valid/ready convention as ch_queue.
- Sustains one input beat per clock when the output side is not back-pressured.
- Provides the width-conversion stage between the queue and wide-datapath consumers.

Parameters:
DATA_WIDTH, 4, width of one input beat (matches ch_queue data width)
RATIO, 4, beats per output word; power of two, minimum 2
(derived) CNT_W = clog2(RATIO); WORD_W = DATA_WIDTH*RATIO

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
io_in_valid  input  1  input beat valid (from ch_queue io_deq_valid)
io_in_data  input  DATA_WIDTH  input beat payload
io_in_ready  output  1  packer accepts beat this cycle (to ch_queue io_deq_ready)
io_out_valid  output  1  packed word valid
io_out_data  output  WORD_W  packed word
io_out_ready  input  1  downstream accepts word
io_count  output  CNT_W  beats currently accumulated toward the next word

Behaviour:
- State:
  - acc: DATA_WIDTH*(RATIO-1) bits, holds partial beats
  - cnt: CNT_W bits
  - out_reg: WORD_W bits
  - out_v: 1 bit
- Reset (synchronous, priority over all else): cnt=0, out_v=0, acc=0, out_reg=0.
  - Outputs after reset: io_out_valid=0, io_out_data=0, io_count=0, io_in_ready=1.
- in_ready = (cnt != RATIO-1) | ~out_v | io_out_ready. Combinational; no combinational path from io_in_valid.
- in_fire = io_in_valid & in_ready. out_fire = out_v & io_out_ready.
- in_fire with cnt < RATIO-1: acc slice [cnt] <= io_in_data; cnt <= cnt+1.
- in_fire with cnt == RATIO-1:
  - out_reg <= {io_in_data, acc}; out_v <= 1; cnt <= 0.
  - Word ordering is little-endian: beat 0 lands in bits [DATA_WIDTH-1:0].
- out_fire without a load that cycle: out_v <= 0. out_fire with a simultaneous load: out_v stays 1 and out_reg takes the new word.
- Latency: io_out_valid rises the cycle after the final beat is accepted. io_out_data stays stable while io_out_valid=1 and io_out_ready=0.
- Throughput: with io_out_ready held 1, io_in_ready never deasserts; one word per RATIO cycles.
- Full condition: out_v=1, cnt=RATIO-1 and io_out_ready=0. io_in_ready=0; the pending beat is held upstream.
- Wrap-around: cnt wraps RATIO-1 -> 0 only on the completing beat, never by overflow.
- Reset mid-word: partial beats are discarded; the next accepted beat becomes beat 0.
- io_count = cnt.

Optional Feature:
CH_NIBBLE_PACKER_FLUSH_EN.
- Enabled, the block adds two ports:
  - io_flush: input, 1 bit
  - io_out_beats: output, CNT_W+1 bits, number of valid beats in io_out_data
- Flush rule:
  - A flush is taken when io_flush=1 and the output slot is free (~out_v | io_out_ready).
  - If an in_fire happens in the same cycle, that beat is included first.
  - The resulting partial word is emitted zero-padded in the upper beats, and cnt <= 0.
  - A flush with zero accumulated beats and no in_fire is ignored.
- Full words report io_out_beats=RATIO.
- While io_flush=1 and the slot is busy, io_in_ready=0.
- Disabled: the ports are absent and behaviour is exactly as above.

Decomposition:
- Package ch_packer_pkg holds:
  - DATA_WIDTH, RATIO, CNT_W, WORD_W constants
  - word_t and beat_t typedefs
- One natural sub-module: ch_packer_outreg, a single-entry valid/ready holding register (out_reg/out_v load/drain logic).
- The top level holds the accumulator and counter.

Test Plan:
- RATIO=4, io_out_ready=1, beats 0x1,0x2,0x3,0x4 on consecutive cycles -> io_out_data=0x4321, io_out_valid=1 for exactly one cycle, starting the cycle after beat 4.
- Eight back-to-back beats 0x0..0x7, io_out_ready=1 -> words 0x3210 then 0x7654; io_in_ready constantly 1.
- io_out_ready=0 after the first word 0x4321:
  - beats 0x5,0x6,0x7 accepted (io_count=3), then io_in_ready=0 and 0x4321 held.
  - Raise io_out_ready and present beat 0x8 -> 0x4321 drains and 0x8765 loads in the same cycle; io_out_valid stays 1.
- Accept 0xA,0xB (io_count=2), pulse reset -> io_count=0, io_out_valid=0; then 0x1..0x4 -> 0x4321.
- Flush enabled: beats 0x9,0xC then io_flush -> io_out_data=0x00C9, io_out_beats=2, io_count=0.
- Flush enabled: io_flush with io_count=0 and no input beat -> no output word produced.

Source files
------------

// File: rtl/ch_packer_pkg.sv
// Shared constants and types for the nibble packer.
// Packs RATIO beats of DATA_WIDTH bits into one WORD_W-bit word.
package ch_packer_pkg;
  localparam int DATA_WIDTH = 4;
  localparam int RATIO      = 4;
  localparam int CNT_W      = $clog2(RATIO);
  localparam int WORD_W     = DATA_WIDTH * RATIO;
  localparam int ACC_W      = DATA_WIDTH * (RATIO - 1);

  typedef logic [DATA_WIDTH-1:0] beat_t;
  typedef logic [WORD_W-1:0]     word_t;
  typedef logic [CNT_W-1:0]      cnt_t;
  typedef logic [CNT_W:0]        beats_t;
endpackage

// File: rtl/ch_packer_outreg.sv
// Single-entry valid/ready holding register for packed words.
// Beat-count sideband exists only when CH_NIBBLE_PACKER_FLUSH_EN is defined.
module ch_packer_outreg
  import ch_packer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] load_word,
`ifdef CH_NIBBLE_PACKER_FLUSH_EN
  input  logic [CNT_W:0]    load_beats,
  output logic [CNT_W:0]    out_beats,
`endif
  input  logic              out_ready,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_word,
  output logic              slot_free
);

  logic  out_v;
  word_t out_reg;

  assign slot_free = ~out_v | out_ready;
  assign out_valid = out_v;
  assign out_word  = out_reg;

  // A load only arrives while the slot is free, so it always wins over a drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_v   <= 1'b0;
      out_reg <= '0;
    end else if (load) begin
      out_v   <= 1'b1;
      out_reg <= load_word;
    end else if (out_v && out_ready) begin
      out_v   <= 1'b0;
    end
  end

`ifdef CH_NIBBLE_PACKER_FLUSH_EN
  beats_t beats_reg;

  always_ff @(posedge clk) begin
    if (reset) beats_reg <= '0;
    else if (load) beats_reg <= load_beats;
  end

  assign out_beats = beats_reg;
`endif

endmodule

// File: rtl/ch_nibble_packer.sv
// Gathers RATIO narrow beats into one little-endian wide word on a valid/ready port.
// Optional partial-word flush enabled by defining CH_NIBBLE_PACKER_FLUSH_EN.
module ch_nibble_packer
  import ch_packer_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  io_in_valid,
  input  logic [DATA_WIDTH-1:0] io_in_data,
  output logic                  io_in_ready,
  output logic                  io_out_valid,
  output logic [WORD_W-1:0]     io_out_data,
  input  logic                  io_out_ready,
`ifdef CH_NIBBLE_PACKER_FLUSH_EN
  input  logic                  io_flush,
  output logic [CNT_W:0]        io_out_beats,
`endif
  output logic [CNT_W-1:0]      io_count
);

  logic [ACC_W-1:0] acc;
  cnt_t             cnt;
  logic             last;
  logic             slot_free;
  logic             in_fire;
  logic             load;
  word_t            load_word;

  assign last     = (cnt == cnt_t'(RATIO - 1));
  assign in_fire  = io_in_valid & io_in_ready;
  assign io_count = cnt;

`ifdef CH_NIBBLE_PACKER_FLUSH_EN
  logic   flush_take;
  beats_t load_beats;
  word_t  acc_ext;

  // A pending flush that cannot be taken stalls input so the beat joins the flushed word.
  assign io_in_ready = (~last | slot_free) & ~(io_flush & ~slot_free);
  assign flush_take  = io_flush & slot_free & ((cnt != '0) | in_fire);
  assign load        = (in_fire & last) | flush_take;
  assign load_beats  = beats_t'(cnt) + beats_t'(in_fire);
  assign acc_ext     = {{DATA_WIDTH{1'b0}}, acc};

  // Beats at or above the fill level are zeroed; the incoming beat fills slot cnt.
  always_comb begin
    load_word = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (cnt_t'(i) < cnt)
        load_word[i*DATA_WIDTH +: DATA_WIDTH] = acc_ext[i*DATA_WIDTH +: DATA_WIDTH];
      else if ((cnt_t'(i) == cnt) && in_fire)
        load_word[i*DATA_WIDTH +: DATA_WIDTH] = io_in_data;
    end
  end
`else
  assign io_in_ready = ~last | slot_free;
  assign load        = in_fire & last;
  assign load_word   = {io_in_data, acc};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      cnt <= '0;
    end else begin
      if (in_fire && !last)
        acc[int'(cnt)*DATA_WIDTH +: DATA_WIDTH] <= io_in_data;
      if (load)
        cnt <= '0;
      else if (in_fire)
        cnt <= cnt_t'(cnt + 1'b1);
    end
  end

  ch_packer_outreg u_outreg (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_word  (load_word),
`ifdef CH_NIBBLE_PACKER_FLUSH_EN
    .load_beats (load_beats),
    .out_beats  (io_out_beats),
`endif
    .out_ready  (io_out_ready),
    .out_valid  (io_out_valid),
    .out_word   (io_out_data),
    .slot_free  (slot_free)
  );

endmodule
